// File: rtl/sme_sbox_pipe.sv
// rtl/sme_sbox_pipe.sv - share-wise masked AES S-box lanes on a LAT-stage stall/flush pipeline
// Per lane: linear top layer, x^254 inversion from DOM GF(2^8) multipliers, linear bottom layer.
module sme_sbox_pipe #(
  parameter int SMAX  = 3,
  parameter int LANES = 4,
  parameter int LAT   = 2
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_dec,
  input  logic [8*LANES-1:0]    in_data [SMAX-1:0],
  input  logic                  rng_valid,
  output logic                  rng_ready,
  input  logic [32*LANES-1:0]   rng_data [SMAX-1:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*LANES-1:0]    out_data [SMAX-1:0],
  output logic                  out_dec,
  output logic [15:0]           cnt_beats,
  output logic [15:0]           cnt_rng_stall
);

  typedef logic [SMAX-1:0][7:0]             shv_t;
  typedef logic [LANES-1:0][SMAX-1:0][7:0]  beat_t;
  typedef logic [3:0][SMAX-1:0][7:0]        rnd_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  function automatic shv_t sq_sh(input shv_t a);
    shv_t r;
    for (int s = 0; s < SMAX; s++) r[s] = gmul(a[s], a[s]);
    return r;
  endfunction

  function automatic shv_t lin_fwd(input shv_t a);
    shv_t r;
    for (int s = 0; s < SMAX; s++)
      r[s] = a[s] ^ rotl8(a[s], 3'd1) ^ rotl8(a[s], 3'd2) ^ rotl8(a[s], 3'd3) ^ rotl8(a[s], 3'd4);
    return r;
  endfunction

  function automatic shv_t lin_inv(input shv_t a);
    shv_t r;
    for (int s = 0; s < SMAX; s++)
      r[s] = rotl8(a[s], 3'd1) ^ rotl8(a[s], 3'd3) ^ rotl8(a[s], 3'd6);
    return r;
  endfunction

  // Cross-share mask r_ij is symmetric in (i,j), so it cancels in the share sum.
  function automatic shv_t dom_mul(input shv_t a, input shv_t b, input shv_t r);
    shv_t z;
    for (int i = 0; i < SMAX; i++) begin
      z[i] = gmul(a[i], b[i]);
      for (int j = 0; j < SMAX; j++) begin
        if (j != i) z[i] = z[i] ^ gmul(a[i], b[j]) ^ rotl8(r[(i > j) ? i : j], 3'((i < j) ? i : j));
      end
    end
    return z;
  endfunction

  function automatic shv_t masked_inv(input shv_t x, input rnd_t r);
    shv_t x2, x3, x12, x15, x240, x252;
    x2   = sq_sh(x);
    x3   = dom_mul(x2, x, r[0]);
    x12  = sq_sh(sq_sh(x3));
    x15  = dom_mul(x12, x3, r[1]);
    x240 = sq_sh(sq_sh(sq_sh(sq_sh(x15))));
    x252 = dom_mul(x240, x12, r[2]);
    return dom_mul(x252, x2, r[3]);
  endfunction

  logic            step;
  logic [LAT-1:0]  vld_q, vld_d, dec_q, dec_d;
  beat_t           st_q [LAT];
  beat_t           front_d, out_d, out_q;
  shv_t            fx, bx;
  rnd_t            fr;
  logic            out_valid_q, out_dec_q;
  logic [15:0]     cnt_beats_q, cnt_stall_q;

  assign step      = (!out_valid_q || out_ready) && rng_valid && !flush;
  assign in_ready  = step;
  assign rng_ready = step;

  always_comb begin
    front_d = '0;
    fx      = '0;
    fr      = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int s = 0; s < SMAX; s++) begin
        fx[s] = in_data[s][8*k +: 8];
        for (int m = 0; m < 4; m++) fr[m][s] = rng_data[s][32*k + 8*m +: 8];
      end
      if (in_dec) begin
        fx    = lin_inv(fx);
        fx[0] = fx[0] ^ 8'h05;
      end
      front_d[k] = masked_inv(fx, fr);
    end
  end

  // Bottom layer follows the dec bit travelling with the beat, not the live input.
  always_comb begin
    out_d = '0;
    bx    = '0;
    for (int k = 0; k < LANES; k++) begin
      bx = st_q[LAT-1][k];
      if (!dec_q[LAT-1]) begin
        bx    = lin_fwd(bx);
        bx[0] = bx[0] ^ 8'h63;
      end
      out_d[k] = bx;
    end
  end

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
    dec_d    = dec_q << 1;
    dec_d[0] = in_dec;
  end

  always_ff @(posedge g_clk) begin
    if (step) begin
      st_q[0] <= front_d;
      for (int i = 1; i < LAT; i++) st_q[i] <= st_q[i-1];
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      vld_q       <= '0;
      dec_q       <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= 1'b0;
      out_q       <= '0;
      cnt_beats_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (flush) begin
        vld_q       <= '0;
        out_valid_q <= 1'b0;
      end else if (step) begin
        vld_q       <= vld_d;
        dec_q       <= dec_d;
        out_valid_q <= vld_q[LAT-1];
        if (vld_q[LAT-1]) begin
          out_q     <= out_d;
          out_dec_q <= dec_q[LAT-1];
        end
      end
      if (out_valid_q && out_ready && !flush) cnt_beats_q <= cnt_beats_q + 16'd1;
      if ((!out_valid_q || out_ready) && !rng_valid && !flush && (in_valid || (|vld_q))
          && (cnt_stall_q != 16'hFFFF))
        cnt_stall_q <= cnt_stall_q + 16'd1;
    end
  end

  always_comb begin
    for (int s = 0; s < SMAX; s++) begin
      out_data[s] = '0;
      for (int k = 0; k < LANES; k++) out_data[s][8*k +: 8] = out_q[k][s];
    end
  end

  assign out_valid     = out_valid_q;
  assign out_dec       = out_dec_q;
  assign cnt_beats     = cnt_beats_q;
  assign cnt_rng_stall = cnt_stall_q;

endmodule

// File: tb/tb_sme_sbox_pipe.sv
// tb/tb_sme_sbox_pipe.sv - directed and randomized checks of sme_sbox_pipe against an S-box table model
module tb_sme_sbox_pipe;
  localparam int S = 3, L = 4, LT = 2;

  logic g_clk = 1'b0;
  logic g_reset, flush, in_valid, in_ready, in_dec, rng_valid, rng_ready;
  logic out_valid, out_ready, out_dec;
  logic [8*L-1:0]  in_data  [S-1:0];
  logic [32*L-1:0] rng_data [S-1:0];
  logic [8*L-1:0]  out_data [S-1:0];
  logic [15:0]     cnt_beats, cnt_rng_stall;

  int tests = 0, fails = 0, cyc = 0, nb = 0;
  bit lat_chk = 1'b0, prev_hold = 1'b0;
  logic [8*L*S-1:0] held;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];
  logic [32:0] pend_q [$];
  logic [32:0] exp_q [$];
  int acc_q [$];
  logic [31:0] rp;
  logic rd;

  sme_sbox_pipe #(.SMAX(S), .LANES(L), .LAT(LT)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_data(in_data),
    .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_data(rng_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dec(out_dec),
    .cnt_beats(cnt_beats), .cnt_rng_stall(cnt_rng_stall)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] p, input logic dec);
    logic [31:0] r;
    for (int k = 0; k < L; k++) r[8*k +: 8] = dec ? isbox[p[8*k +: 8]] : sbox[p[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] unmask(input logic [8*L-1:0] a [S-1:0]);
    logic [31:0] r;
    r = '0;
    for (int s = 0; s < S; s++) r = r ^ a[s];
    return r;
  endfunction

  function automatic logic [8*L*S-1:0] pack(input logic [8*L-1:0] a [S-1:0]);
    logic [8*L*S-1:0] r;
    for (int s = 0; s < S; s++) r[8*L*s +: 8*L] = a[s];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mask(input logic [31:0] p);
    logic [31:0] a;
    a = p;
    for (int s = 1; s < S; s++) begin
      in_data[s] = $urandom;
      a = a ^ in_data[s];
    end
    in_data[0] = a;
  endtask

  task automatic tick();
    logic [32:0] e;
    int a;
    in_valid = (pend_q.size() != 0);
    if (in_valid) begin
      in_dec = pend_q[0][32];
      mask(pend_q[0][31:0]);
    end else begin
      in_dec = 1'($urandom);
      mask($urandom);
    end
    for (int s = 0; s < S; s++) rng_data[s] = {$urandom, $urandom, $urandom, $urandom};
    #1;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", pack(out_data), held);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        nb++;
        chk("out_data", unmask(out_data), e[31:0]);
        chk("out_dec", out_dec, e[32]);
        if (lat_chk) chk("latency", cyc - a, LT + 1);
      end
    end
    prev_hold = out_valid && !out_ready && !flush;
    held = pack(out_data);
    if (in_valid && in_ready) begin
      e = pend_q.pop_front();
      exp_q.push_back({e[32], model(e[31:0], e[32])});
      acc_q.push_back(cyc);
    end
    if (flush) begin
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge g_clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (pend_q.size() != 0 || exp_q.size() != 0); i++) tick();
    chk("drain_empty", exp_q.size() + pend_q.size(), 0);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = affine(inv);
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    g_reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_dec = 1'b0;
    rng_valid = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < S; s++) begin
      in_data[s] = '0;
      rng_data[s] = '0;
    end
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_dec", out_dec, 0);
    chk("rst_out_data", pack(out_data), 0);
    chk("rst_cnt_beats", cnt_beats, 0);
    chk("rst_cnt_stall", cnt_rng_stall, 0);
    #2 g_reset = 1'b0;

    // Known forward vector, accepted on the first edge after reset release
    lat_chk = 1'b1;
    pend_q.push_back({1'b0, 32'h01FF5300});
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("fwd_known", unmask(out_data), 32'h7C16ED63);
    chk("fwd_known_dec", out_dec, 0);
    drain();

    // Inverse then forward beat back-to-back
    rp = $urandom;
    pend_q.push_back({1'b1, 32'h7C16ED63});
    pend_q.push_back({1'b0, rp});
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("inv_known", unmask(out_data), 32'h01FF5300);
    chk("inv_known_dec", out_dec, 1);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_dec", out_dec, 0);
    chk("b2b_data", unmask(out_data), model(rp, 1'b0));
    drain();

    // Eight beats with a 3-cycle output backpressure mid-stream
    lat_chk = 1'b0;
    for (int i = 0; i < 8; i++) pend_q.push_back({1'($urandom), 32'($urandom)});
    repeat (4) tick();
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    drain();
    chk("cnt_beats_11", cnt_beats, 11);
    chk("cnt_beats_model", cnt_beats, nb);

    // Randomness starvation with two beats in flight
    pend_q.push_back({1'b0, 32'($urandom)});
    pend_q.push_back({1'b1, 32'($urandom)});
    tick();
    tick();
    rng_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_rng_ready", rng_ready, 0);
      chk("stall_out_valid", out_valid, 0);
    end
    chk("cnt_rng_stall_5", cnt_rng_stall, 5);
    rng_valid = 1'b1;
    drain();

    // Flush with two beats in flight and a held output
    for (int i = 0; i < 3; i++) pend_q.push_back({1'($urandom), 32'($urandom)});
    repeat (3) tick();
    chk("pre_flush_valid", out_valid, 1);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_rng_ready", rng_ready, 0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < LT + 2; i++) begin
      tick();
      chk("flush_no_emerge", out_valid, 0);
    end
    chk("flush_cnt_beats", cnt_beats, 13);

    // Reset asserted between edges mid-stream
    for (int i = 0; i < 4; i++) pend_q.push_back({1'($urandom), 32'($urandom)});
    repeat (4) tick();
    #2 g_reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_beats", cnt_beats, 0);
    chk("async_rst_stall", cnt_rng_stall, 0);
    chk("async_rst_dec", out_dec, 0);
    chk("async_rst_data", pack(out_data), 0);
    pend_q.delete();
    exp_q.delete();
    acc_q.delete();
    prev_hold = 1'b0;
    nb = 0;
    #1 g_reset = 1'b0;

    // Same unmasked beat under fresh random masks each time
    lat_chk = 1'b1;
    rp = $urandom;
    rd = 1'($urandom);
    for (int i = 0; i < 6; i++) pend_q.push_back({rd, rp});
    drain();
    chk("remask_cnt", cnt_beats, 6);

    // Random traffic with random backpressure and starvation
    lat_chk = 1'b0;
    for (int i = 0; i < 24; i++) pend_q.push_back({1'($urandom), 32'($urandom)});
    for (int i = 0; i < 300 && (pend_q.size() != 0 || exp_q.size() != 0); i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rng_valid = out_ready ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    rng_valid = 1'b1;
    drain();
    chk("rand_cnt_beats", cnt_beats, 30);
    chk("rand_cnt_model", cnt_beats, nb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
